commit_trace_buffer: RTL

Downstream observer of the core's writeback and data-memory-write outputs. Each cycle with an architectural side effect is captured as one timestamped trace entry: a register write to x1–x31, a store, or both. Entries are queued in a FIFO and drained through a valid/ready port by the testbench monitor or a debug UART. Overflow drops entries but never stalls the core, and drops are counted.

---
 rtl/trace_pkg.sv | 24 ++
 rtl/trace_fifo.sv | 55 +++++
 rtl/commit_trace_buffer.sv | 118 +++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared kind-bit positions, field widths and the default trace entry layout
// used by the commit trace buffer and its FIFO.
package trace_pkg;

  localparam int unsigned KIND_REG  = 0;
  localparam int unsigned KIND_MEM  = 1;

  localparam int unsigned KIND_W    = 2;
  localparam int unsigned REG_NUM_W = 5;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TS_W      = 16;
  localparam int unsigned DROP_W    = 16;

  typedef struct packed {
    logic [KIND_W-1:0]    kind;
    logic [REG_NUM_W-1:0] reg_num;
    logic [DATA_W-1:0]    reg_data;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wr_data;
    logic [TS_W-1:0]      ts;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries; a push while full is taken when a pop
// frees the head slot on the same edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures register writes (x1-x31) and stores as timestamped trace entries
// and queues them for a valid/ready consumer; overflow drops and counts.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic                   reg_write_sig,
  input  logic [REG_NUM_W-1:0]   reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [KIND_W-1:0]      out_kind,
  output logic [REG_NUM_W-1:0]   out_reg_num,
  output logic [DATA_W-1:0]      out_reg_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_wr_data,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  // Same layout as trace_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [KIND_W-1:0]    kind;
    logic [REG_NUM_W-1:0] reg_num;
    logic [DATA_W-1:0]    reg_data;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wr_data;
    logic [TS_W-1:0]      ts;
  } entry_t;

  logic            reg_ev;
  logic            mem_ev;
  logic            push_req;
  logic            pop;
  logic            drop;
  logic            full;
  logic            empty;
  logic [TS_W-1:0] ts;
  entry_t          entry;
  entry_t          head;

  assign reg_ev   = reg_write_sig && (reg_num != '0);
  assign mem_ev   = wr;
  assign push_req = trace_en && (reg_ev || mem_ev);
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;
  assign drop     = push_req && full && !pop;

  always_comb begin
    entry                = '0;
    entry.kind[KIND_REG] = reg_ev;
    entry.kind[KIND_MEM] = mem_ev;
    if (reg_ev) begin
      entry.reg_num  = reg_num;
      entry.reg_data = reg_data;
    end
    if (mem_ev) begin
      entry.addr    = addr;
      entry.wr_data = wr_data;
    end
    entry.ts = ts;
  end

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_kind     = head.kind;
  assign out_reg_num  = head.reg_num;
  assign out_reg_data = head.reg_data;
  assign out_addr     = head.addr;
  assign out_wr_data  = head.wr_data;
  assign out_ts       = head.ts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  // A drop coinciding with clear restarts the count at one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear)                drop_count <= DROP_W'(1);
      else if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule
